// File: rtl/mem_slave.sv
// mem_slave: memory-side responder behind the core's external memory ports.
// A word array of 2**ADDR_W 64-bit entries sits behind two independent
// handshake FSMs. The read channel and the write channel each have their own
// programmable latency, so both channels can be busy at the same time.
//
// Ports:
//   clk, rst            - rising-edge clock; asynchronous active-low reset
//   READ_SIGNAL         - read request level
//   READ_ADDR           - read byte address, latched when the read is accepted
//   READ_DATA           - read data; valid while READ_FINISH=1 and held afterwards
//   READ_FINISH         - one-cycle read completion pulse
//   DATA_ARRIVE         - write request level
//   DATA, DATA_ADDR     - write doubleword and byte address, latched when the write is accepted
//   DATA_RECIVED        - one-cycle write completion pulse
//   bus_err             - sticky flag for out-of-range accesses
//   bus_err_addr        - address of the first out-of-range access
//   rd_count, wr_count  - completion counters (only when MEM_SLAVE_STATS_EN is defined)
//
// Optional feature macro: MEM_SLAVE_STATS_EN
//
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for READ_SIGNAL
//   R_BUSY | latency down-counter running
//   R_DONE | READ_FINISH high, READ_DATA valid
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for DATA_ARRIVE
//   W_BUSY | latency down-counter running
//   W_ACK  | DATA_RECIVED high; array commit happened on entry

module mem_slave #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        READ_SIGNAL,
    input  logic [63:0] READ_ADDR,
    output logic [63:0] READ_DATA,
    output logic        READ_FINISH,
    input  logic        DATA_ARRIVE,
    input  logic [63:0] DATA,
    input  logic [63:0] DATA_ADDR,
    output logic        DATA_RECIVED,
    output logic        bus_err,
    output logic [63:0] bus_err_addr
`ifdef MEM_SLAVE_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    // The range check uses 65 bits so that a window ending at 2**64 does not wrap.
    localparam logic [64:0] SPAN    = 65'(DEPTH) << 3;
    localparam logic [64:0] LIMIT   = {1'b0, BASE_ADDR} + SPAN;
    localparam logic [3:0]  RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0]  WR_LOAD = 4'(WRITE_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_ACK}  wr_state_t;

    function automatic logic in_range(input logic [63:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [63:0] a);
        return ADDR_W'((a - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem [DEPTH];

    rd_state_t   rd_state, rd_state_nx;
    logic [3:0]  rd_cnt;
    logic [63:0] rd_addr_q;
    wr_state_t   wr_state, wr_state_nx;
    logic [3:0]  wr_cnt;
    logic [63:0] wr_addr_q;
    logic [63:0] wr_data_q;

    logic              rd_accept, wr_accept;
    logic              rd_sample, wr_commit;
    logic [63:0]       rd_cur_addr, wr_cur_addr, wr_cur_data;
    logic              rd_cur_ok, wr_cur_ok;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              rd_acc_err, wr_acc_err;

    assign rd_accept = (rd_state == R_IDLE) && READ_SIGNAL;
    assign wr_accept = (wr_state == W_IDLE) && DATA_ARRIVE;

    // With a latency of 1, the edge that accepts a request is also the edge that
    // samples or commits it. The latched copies are not loaded yet at that point,
    // so the live inputs are used while the FSM is idle.
    assign rd_cur_addr = (rd_state == R_IDLE) ? READ_ADDR : rd_addr_q;
    assign wr_cur_addr = (wr_state == W_IDLE) ? DATA_ADDR : wr_addr_q;
    assign wr_cur_data = (wr_state == W_IDLE) ? DATA      : wr_data_q;

    assign rd_cur_ok = in_range(rd_cur_addr);
    assign wr_cur_ok = in_range(wr_cur_addr);
    assign rd_idx    = word_idx(rd_cur_addr);
    assign wr_idx    = word_idx(wr_cur_addr);

    assign rd_sample = (rd_state_nx == R_DONE) && (rd_state != R_DONE);
    assign wr_commit = (wr_state_nx == W_ACK)  && (wr_state != W_ACK);

    assign rd_acc_err = rd_accept && !in_range(READ_ADDR);
    assign wr_acc_err = wr_accept && !in_range(DATA_ADDR);

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_state <= R_IDLE;
        else      rd_state <= rd_state_nx;
    end

    // The count reaches zero on the same edge that enters R_DONE, so the
    // terminal-count compare is against 1.
    always_comb begin
        rd_state_nx = rd_state;
        case (rd_state)
            R_IDLE:  if (READ_SIGNAL) rd_state_nx = (READ_LAT == 1) ? R_DONE : R_BUSY;
            R_BUSY:  if (rd_cnt == 4'd1) rd_state_nx = R_DONE;
            R_DONE:  rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        READ_FINISH  = (rd_state == R_DONE);
        DATA_RECIVED = (wr_state == W_ACK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt    <= 4'd0;
            rd_addr_q <= 64'd0;
        end else if (rd_accept) begin
            rd_cnt    <= RD_LOAD;
            rd_addr_q <= READ_ADDR;
        end else if (rd_state == R_BUSY) begin
            rd_cnt    <= rd_cnt - 4'd1;
        end
    end

    // Write-first bypass: a commit to the same word on the sample edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            READ_DATA <= 64'd0;
        end else if (rd_sample) begin
            if (!rd_cur_ok)
                READ_DATA <= 64'd0;
            else if (wr_commit && wr_cur_ok && (wr_idx == rd_idx))
                READ_DATA <= wr_cur_data;
            else
                READ_DATA <= mem[rd_idx];
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_state <= W_IDLE;
        else      wr_state <= wr_state_nx;
    end

    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            W_IDLE:  if (DATA_ARRIVE) wr_state_nx = (WRITE_LAT == 1) ? W_ACK : W_BUSY;
            W_BUSY:  if (wr_cnt == 4'd1) wr_state_nx = W_ACK;
            W_ACK:   wr_state_nx = W_IDLE;
            default: wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= 4'd0;
            wr_addr_q <= 64'd0;
            wr_data_q <= 64'd0;
        end else if (wr_accept) begin
            wr_cnt    <= WR_LOAD;
            wr_addr_q <= DATA_ADDR;
            wr_data_q <= DATA;
        end else if (wr_state == W_BUSY) begin
            wr_cnt    <= wr_cnt - 4'd1;
        end
    end

    // The array has no reset. The rst qualifier blocks a latency-1 write that
    // is requested while the block is held in reset.
    always_ff @(posedge clk) begin
        if (rst && wr_commit && wr_cur_ok)
            mem[wr_idx] <= wr_cur_data;
    end

    // ---------------- error capture ----------------
    // When a read and a write are both out of range on the same edge, the
    // read address is the one recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err      <= 1'b0;
            bus_err_addr <= 64'd0;
        end else if (!bus_err && (rd_acc_err || wr_acc_err)) begin
            bus_err      <= 1'b1;
            bus_err_addr <= rd_acc_err ? READ_ADDR : DATA_ADDR;
        end
    end

`ifdef MEM_SLAVE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            if (READ_FINISH)  rd_count <= rd_count + 32'd1;
            if (DATA_RECIVED) wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_slave.sv
module tb_mem_slave;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          AW    = 12;
    localparam int          DEPTH = 2 ** AW;
    localparam int          RL    = 2;
    localparam int          WL    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        READ_SIGNAL, READ_FINISH, DATA_ARRIVE, DATA_RECIVED, bus_err;
    logic [63:0] READ_ADDR, READ_DATA, DATA, DATA_ADDR, bus_err_addr;

    logic        rs2, rfin2, drcv2, berr2;
    logic [63:0] ra2, rdat2, beaddr2;
    logic        da2 = 1'b0;
    logic [63:0] dd2 = 64'd0;
    logic [63:0] dad2 = 64'd0;

`ifdef MEM_SLAVE_STATS_EN
    logic [31:0] rd_count, wr_count, rd_count2, wr_count2;
`endif

    always #5 clk = ~clk;

    mem_slave #(.ADDR_W(AW), .BASE_ADDR(BASE), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk(clk), .rst(rst),
        .READ_SIGNAL(READ_SIGNAL), .READ_ADDR(READ_ADDR),
        .READ_DATA(READ_DATA), .READ_FINISH(READ_FINISH),
        .DATA_ARRIVE(DATA_ARRIVE), .DATA(DATA), .DATA_ADDR(DATA_ADDR),
        .DATA_RECIVED(DATA_RECIVED), .bus_err(bus_err), .bus_err_addr(bus_err_addr)
`ifdef MEM_SLAVE_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    // A second instance with a read latency of 1, used for the back-to-back read case.
    mem_slave #(.ADDR_W(AW), .BASE_ADDR(BASE), .READ_LAT(1), .WRITE_LAT(WL)) dut2 (
        .clk(clk), .rst(rst),
        .READ_SIGNAL(rs2), .READ_ADDR(ra2),
        .READ_DATA(rdat2), .READ_FINISH(rfin2),
        .DATA_ARRIVE(da2), .DATA(dd2), .DATA_ADDR(dad2),
        .DATA_RECIVED(drcv2), .bus_err(berr2), .bus_err_addr(beaddr2)
`ifdef MEM_SLAVE_STATS_EN
        , .rd_count(rd_count2), .wr_count(wr_count2)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a sparse word store plus the sticky error record.
    logic [63:0] ref_mem [int];
    bit          ref_err;
    logic [63:0] ref_err_addr;

    function automatic bit m_in(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    task automatic model_apply(input bit wr, input logic [63:0] addr, input logic [63:0] data);
        if (!m_in(addr)) begin
            if (!ref_err) begin
                ref_err      = 1'b1;
                ref_err_addr = addr;
            end
        end else if (wr) begin
            ref_mem[m_idx(addr)] = data;
        end
    endtask

    // Runs one full handshake. Inputs are driven at a negedge and the request
    // is dropped 1ns after the accept edge. Afterwards the address and data
    // inputs are scrambled, because the DUT must ignore them once it has
    // accepted the request. Latency is counted in cycles after the accept cycle.
    task automatic do_op(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output int lat, output int width);
        logic p;
        @(negedge clk);
        if (wr) begin
            DATA_ARRIVE = 1'b1; DATA_ADDR = addr; DATA = wdata;
        end else begin
            READ_SIGNAL = 1'b1; READ_ADDR = addr;
        end
        @(posedge clk);
        #1;
        READ_SIGNAL = 1'b0; DATA_ARRIVE = 1'b0;
        READ_ADDR = ~addr; DATA_ADDR = ~addr; DATA = ~wdata;
        lat = -1; width = 0; rdata = 64'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            p = wr ? DATA_RECIVED : READ_FINISH;
            if (p) begin
                if (lat < 0) begin
                    lat   = c;
                    rdata = READ_DATA;
                end
                width++;
            end else if (lat >= 0) begin
                break;
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp_data;
        bit          exp_err;
        logic [63:0] exp_err_addr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];
    bit   exp_pat [8];
    int   pool  [16];

    initial begin
        logic [63:0] rd;
        logic [63:0] a, d, e;
        int          lat, wid, np, idx;
        bit          wr;

        vecs[0]  = '{1'b1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 64'h8000_0013, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0};
        vecs[3]  = '{1'b1, 64'h8000_7FF8, 64'hA5A5_5A5A_C3C3_3C3C, 64'h0, 1'b0, 64'h0};
        vecs[4]  = '{1'b0, 64'h8000_7FFF, 64'h0, 64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 64'h8000_0000, 64'h0000_0000_0000_0123, 64'h0, 1'b0, 64'h0};
        vecs[6]  = '{1'b0, 64'h8000_0007, 64'h0, 64'h0000_0000_0000_0123, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, 64'h7FFF_FFF8, 64'h0, 64'h0, 1'b1, 64'h7FFF_FFF8};
        vecs[8]  = '{1'b1, 64'h9000_0000, 64'h1234_5678, 64'h0, 1'b1, 64'h7FFF_FFF8};
        vecs[9]  = '{1'b0, 64'h8000_8000, 64'h0, 64'h0, 1'b1, 64'h7FFF_FFF8};
        vecs[10] = '{1'b0, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'h7FFF_FFF8};
        exp_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        READ_SIGNAL = 1'b0; READ_ADDR = 64'd0;
        DATA_ARRIVE = 1'b0; DATA = 64'd0; DATA_ADDR = 64'd0;
        rs2 = 1'b0; ra2 = 64'd0;
        ref_err = 1'b0; ref_err_addr = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst_read_finish", 64'(READ_FINISH), 64'd0);
        chk("rst_data_recived", 64'(DATA_RECIVED), 64'd0);
        chk("rst_read_data", READ_DATA, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_bus_err_addr", bus_err_addr, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_read_finish", 64'(READ_FINISH), 64'd0);

        // Back-to-back reads at latency 1: READ_SIGNAL held for 6 cycles.
        rs2 = 1'b1; ra2 = BASE + 64'h10;
        np = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_cycle%0d", c), 64'(rfin2), 64'(exp_pat[c]));
            np += int'(rfin2);
            if (c == 5) rs2 = 1'b0;
        end
        chk("b2b_pulses", 64'(np), 64'd3);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat, wid);
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].data);
            chk($sformatf("v%0d_latency", i), 64'(lat), vecs[i].wr ? 64'(WL) : 64'(RL));
            chk($sformatf("v%0d_pulse_width", i), 64'(wid), 64'd1);
            if (!vecs[i].wr) begin
                chk($sformatf("v%0d_read_data", i), rd, vecs[i].exp_data);
                chk($sformatf("v%0d_read_hold", i), READ_DATA, vecs[i].exp_data);
            end
            chk($sformatf("v%0d_bus_err", i), 64'(bus_err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_bus_err_addr", i), bus_err_addr, vecs[i].exp_err_addr);
        end

        // Collision: the write commit lands on the read's sample edge, same word.
        do_op(1'b1, 64'h8000_0020, 64'h0, rd, lat, wid);
        model_apply(1'b1, 64'h8000_0020, 64'h0);
        @(negedge clk);
        READ_SIGNAL = 1'b1; READ_ADDR = 64'h8000_0020;
        @(posedge clk);
        #1;
        READ_SIGNAL = 1'b0; READ_ADDR = 64'd0;
        DATA_ARRIVE = 1'b1; DATA = 64'h1111; DATA_ADDR = 64'h8000_0020;
        // Write accept offset chosen so commit edge == read sample edge.
        repeat ((RL - 1) - (WL - 1) - 1) @(posedge clk);
        @(posedge clk);
        #1;
        DATA_ARRIVE = 1'b0;
        model_apply(1'b1, 64'h8000_0020, 64'h1111);
        @(negedge clk);
        chk("coll_read_finish", 64'(READ_FINISH), 64'd1);
        chk("coll_data_recived", 64'(DATA_RECIVED), 64'd1);
        chk("coll_read_data", READ_DATA, 64'h1111);
        @(negedge clk);
        chk("coll_finish_drop", 64'(READ_FINISH), 64'd0);
        do_op(1'b0, 64'h8000_0020, 64'h0, rd, lat, wid);
        chk("coll_readback", rd, 64'h1111);

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 16; i++) begin
            pool[i] = 16 + int'($urandom_range(0, 4000));
            a = BASE + 64'(pool[i]) * 64'd8;
            d = {$urandom, $urandom};
            do_op(1'b1, a, d, rd, lat, wid);
            model_apply(1'b1, a, d);
        end
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    a = BASE - 64'(8 * $urandom_range(1, 1000));
                else
                    a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 100000));
            end else begin
                idx = pool[$urandom_range(0, 15)];
                a = BASE + 64'(idx) * 64'd8 + 64'($urandom_range(0, 7));
            end
            d = {$urandom, $urandom};
            do_op(wr, a, d, rd, lat, wid);
            model_apply(wr, a, d);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), wr ? 64'(WL) : 64'(RL));
            if (!wr) begin
                if (!m_in(a)) e = 64'd0;
                else if (ref_mem.exists(m_idx(a))) e = ref_mem[m_idx(a)];
                else e = rd;
                chk($sformatf("rnd%0d_read_data_a%h", i, a), rd, e);
            end
            chk($sformatf("rnd%0d_bus_err", i), 64'(bus_err), 64'(ref_err));
            chk($sformatf("rnd%0d_bus_err_addr", i), bus_err_addr, ref_err_addr);
        end

        // Reset asserted while a read is in R_BUSY.
        do_op(1'b0, 64'h8000_0010, 64'h0, rd, lat, wid);
        chk("pre_rst_read", rd, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        READ_SIGNAL = 1'b1; READ_ADDR = 64'h8000_0010;
        @(posedge clk);
        #1;
        READ_SIGNAL = 1'b0;
        #1;
        rst = 1'b0;
        ref_err = 1'b0; ref_err_addr = 64'd0;
        #1;
        chk("midrst_read_finish", 64'(READ_FINISH), 64'd0);
        chk("midrst_read_data", READ_DATA, 64'd0);
        chk("midrst_bus_err", 64'(bus_err), 64'd0);
        chk("midrst_bus_err_addr", bus_err_addr, 64'd0);
        np = 0;
        repeat (2) begin
            @(negedge clk);
            np += int'(READ_FINISH);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            np += int'(READ_FINISH);
        end
        chk("midrst_no_pulse", 64'(np), 64'd0);
`ifdef MEM_SLAVE_STATS_EN
        chk("midrst_rd_count", 64'(rd_count), 64'd0);
        chk("midrst_wr_count", 64'(wr_count), 64'd0);
`endif
        do_op(1'b0, 64'h8000_0010, 64'h0, rd, lat, wid);
        chk("postrst_read_data", rd, 64'hDEAD_BEEF_0123_4567);
        chk("postrst_latency", 64'(lat), 64'(RL));
        chk("postrst_bus_err", 64'(bus_err), 64'(ref_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_slave.md
Name: mem_slave

Overview:
- Memory-side responder that sits directly downstream of the CPU core's external memory ports.
- Serves the read channel (READ_SIGNAL/READ_ADDR -> READ_DATA/READ_FINISH) and the write channel (DATA_ARRIVE/DATA/DATA_ADDR -> DATA_RECIVED).
- Backed by an internal 64-bit-wide word array with programmable access latency, so the core's AXI4 read arbiter and write module see realistic multi-cycle handshakes.
- Read and write channels run independent FSMs and may be busy at the same time.

Parameters:
ADDR_W, 12, word-index width; array depth = 2**ADDR_W 64-bit words (32 KiB default)
BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0
READ_LAT, 2, cycles from read accept to READ_FINISH; legal range 1..15
WRITE_LAT, 1, cycles from write accept to DATA_RECIVED; legal range 1..15

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-low reset
READ_SIGNAL  input  1  read request level from core
READ_ADDR  input  64  read byte address
READ_DATA  output  64  read data, valid while READ_FINISH=1, held afterwards
READ_FINISH  output  1  one-cycle read completion pulse
DATA_ARRIVE  input  1  write request level from core
DATA  input  64  write data (full doubleword)
DATA_ADDR  input  64  write byte address
DATA_RECIVED  output  1  one-cycle write completion pulse
bus_err  output  1  sticky out-of-range flag
bus_err_addr  output  64  address of first out-of-range access

Behaviour:
- Reset (rst=0, async): READ_FINISH=0, DATA_RECIVED=0, READ_DATA=0, bus_err=0, bus_err_addr=0; both FSMs -> IDLE; in-flight operations abandoned with no pulse issued; array contents not cleared.
- Address decode:
  - index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 8*2**ADDR_W (64-bit unsigned compare, no wrap).
- Read FSM, states R_IDLE, R_BUSY, R_DONE:
  - R_IDLE: if READ_SIGNAL=1 at a clock edge, latch READ_ADDR, load counter with READ_LAT-1, go to R_BUSY (or straight to R_DONE when READ_LAT=1).
  - R_BUSY: decrement the counter; at 0 go to R_DONE.
  - R_DONE: READ_FINISH=1 for exactly this cycle; READ_DATA = array[index], or 64'h0 if out of range; return to R_IDLE.
  - Latency: request accepted at edge E0 -> READ_FINISH high in the cycle after edge E0+READ_LAT-1, i.e. READ_LAT cycles after the accept cycle.
  - READ_ADDR changes after accept are ignored.
  - READ_SIGNAL still high in the cycle after R_DONE is treated as a new request (back-to-back reads allowed). The requester drops READ_SIGNAL on seeing READ_FINISH.
- Write FSM, states W_IDLE, W_BUSY, W_ACK, same structure as the read FSM:
  - Latches DATA and DATA_ADDR on accept.
  - The array write commits on the edge that enters W_ACK.
  - DATA_RECIVED=1 for exactly one cycle in W_ACK.
  - Out-of-range writes are dropped but still acknowledged.
- Collision: if the read's array sample cycle coincides with a write commit to the same index, READ_DATA returns the new write data (write-first bypass).
- bus_err: set on accept of any out-of-range read or write. bus_err_addr captures that address only when bus_err was 0; both stay sticky until reset.
- Read and write accepted in the same cycle: both proceed independently, no mutual stall.

Optional Feature:
MEM_SLAVE_STATS_EN
- Defined: adds outputs rd_count[31:0] and wr_count[31:0], reset to 0.
  - Each increments by 1 in the cycle its FINISH/RECIVED pulse fires, including out-of-range accesses.
  - Both wrap 32'hFFFF_FFFF -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then write DATA=64'hDEAD_BEEF_0123_4567 to 64'h8000_0010 -> DATA_RECIVED pulses one cycle, WRITE_LAT cycles after accept; read of 64'h8000_0010 returns that value with READ_FINISH exactly READ_LAT cycles after accept.
- Read 64'h8000_0013 after the previous write -> same data (low 3 bits ignored).
- Read 64'h7FFF_FFF8 -> READ_DATA=0, bus_err=1, bus_err_addr=64'h7FFF_FFF8; a later write to 64'h9000_0000 leaves bus_err_addr unchanged.
- READ_LAT=1 with READ_SIGNAL held high for 6 cycles -> READ_FINISH pulses every 2nd cycle (3 pulses); each pulse lasts 1 cycle.
- Write 64'h1111 to 64'h8000_0020 timed so its commit coincides with a read sample of the same word (initially 64'h0) -> read returns 64'h1111.
- Assert rst=0 mid-read (R_BUSY) -> outputs clear immediately and no READ_FINISH is issued; after release, a read of 64'h8000_0010 still returns 64'hDEAD_BEEF_0123_4567. With MEM_SLAVE_STATS_EN defined, rd_count=0 and wr_count=0 after the reset.
